// File: rtl/dino_pkg.sv
// Shared types and defaults for the dinosaur game controller.
// The state encoding is visible on the game_sequencer state port.
package dino_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_PAUSE = 3'd2,
        S_HIT   = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    localparam logic [1:0]  MAX_LEVEL           = 2'd3;

    localparam logic [31:0] TICK_BASE_DEF       = 32'd25000;
    localparam logic [31:0] SPEED_STEP_DEF      = 32'd5000;
    localparam logic [15:0] LEVEL_UP_STEPS_DEF  = 16'd64;
    localparam logic [2:0]  LIVES_DEF           = 3'd3;
    localparam logic [3:0]  INVUL_STEPS_DEF     = 4'd8;

endpackage

// File: rtl/game_sequencer_btn_edge.sv
// Button conditioner: two-flop synchronizer plus falling-edge detect.
// press is high for one cycle, two edges after the pin falls.
module btn_edge (
    input  logic clock,
    input  logic restart,
    input  logic btn_n,
    output logic press
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;

    // Released level is 1, so reset never produces a phantom press.
    always_ff @(posedge clock) begin
        if (!restart) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync1 <= btn_n;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign press = r_prev & ~r_sync2;

endmodule

// File: rtl/game_sequencer.sv
// Game state machine, step divider, lives and speed level.
// Define SPEEDUP_EN to compile the step counter and speed-level logic.
module game_sequencer
    import dino_pkg::*;
#(
    parameter logic [31:0] TICK_BASE      = TICK_BASE_DEF,
    parameter logic [31:0] SPEED_STEP     = SPEED_STEP_DEF,
    parameter logic [15:0] LEVEL_UP_STEPS = LEVEL_UP_STEPS_DEF,
    parameter logic [2:0]  LIVES          = LIVES_DEF,
    parameter logic [3:0]  INVUL_STEPS    = INVUL_STEPS_DEF
) (
    input  logic       clock,
    input  logic       restart,
    input  logic       start,
    input  logic       stop,
    input  logic       hit,
    output logic       step,
    output logic       run_en,
    output logic [2:0] life,
    output logic [1:0] speed_level,
    output logic [2:0] state,
    output logic       game_over,
    output logic       blink
);

    state_t      r_state;
    state_t      w_next;
    logic        w_start_p;
    logic        w_stop_p;
    logic [31:0] r_div;
    logic [31:0] w_period;
    logic        w_wrap;
    logic        w_stay_play;
    logic        w_init;
    logic        r_step;
    logic        r_run_en;
    logic        r_game_over;
    logic        r_blink;
    logic [2:0]  r_life;
    logic [3:0]  r_invul;
    logic [1:0]  w_level;

    btn_edge u_start_btn (
        .clock   (clock),
        .restart (restart),
        .btn_n   (start),
        .press   (w_start_p)
    );

    btn_edge u_stop_btn (
        .clock   (clock),
        .restart (restart),
        .btn_n   (stop),
        .press   (w_stop_p)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_OVER, S_PAUSE: begin
                if (w_start_p && !w_stop_p) w_next = S_RUN;
            end
            S_RUN: begin
                if (hit)           w_next = (r_life > 3'd1) ? S_HIT : S_OVER;
                else if (w_stop_p) w_next = S_PAUSE;
            end
            S_HIT: begin
                if (r_step && (r_invul == INVUL_STEPS - 4'd1)) w_next = S_RUN;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!restart) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // Divider only runs on edges that stay in play, so step cannot land outside RUN/HIT.
    assign w_stay_play = ((r_state == S_RUN) || (r_state == S_HIT)) &&
                         ((w_next == S_RUN)  || (w_next == S_HIT));
    assign w_init      = ((r_state == S_IDLE) || (r_state == S_OVER)) && (w_next == S_RUN);
    assign w_period    = TICK_BASE - (32'(w_level) * SPEED_STEP);
    assign w_wrap      = (r_div == w_period - 32'd1);

    always_ff @(posedge clock) begin
        if (!restart) begin
            r_div  <= '0;
            r_step <= 1'b0;
        end else begin
            r_step <= w_stay_play && w_wrap;
            if (w_init)           r_div <= '0;
            else if (w_stay_play) r_div <= w_wrap ? '0 : r_div + 32'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!restart) begin
            r_life      <= LIVES;
            r_invul     <= '0;
            r_run_en    <= 1'b0;
            r_game_over <= 1'b0;
            r_blink     <= 1'b0;
        end else begin
            if (w_init)
                r_life <= LIVES;
            else if ((r_state == S_RUN) && (w_next == S_HIT))
                r_life <= r_life - 3'd1;
            else if ((r_state == S_RUN) && (w_next == S_OVER))
                r_life <= '0;

            r_invul     <= ((r_state == S_HIT) && (w_next == S_HIT)) ? r_invul + 4'(r_step) : '0;
            r_run_en    <= (w_next == S_RUN) || (w_next == S_HIT);
            r_game_over <= (w_next == S_OVER);

            if (w_next != S_HIT)           r_blink <= 1'b0;
            else if (w_stay_play && w_wrap) r_blink <= ~r_blink;
        end
    end

`ifdef SPEEDUP_EN
    logic [15:0] r_step_cnt;
    logic [1:0]  r_level;

    always_ff @(posedge clock) begin
        if (!restart) begin
            r_step_cnt <= '0;
            r_level    <= '0;
        end else if (w_init) begin
            r_step_cnt <= '0;
            r_level    <= '0;
        end else if (w_stay_play && w_wrap) begin
            if (r_step_cnt == LEVEL_UP_STEPS - 16'd1) begin
                r_step_cnt <= '0;
                if (r_level != MAX_LEVEL) r_level <= r_level + 2'd1;
            end else begin
                r_step_cnt <= r_step_cnt + 16'd1;
            end
        end
    end

    assign w_level = r_level;
`else
    logic w_unused_cfg;
    assign w_unused_cfg = ^LEVEL_UP_STEPS;
    assign w_level      = '0;
`endif

    assign step        = r_step;
    assign run_en      = r_run_en;
    assign life        = r_life;
    assign speed_level = w_level;
    assign state       = r_state;
    assign game_over   = r_game_over;
    assign blink       = r_blink;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed self-checking bench for game_sequencer with a shortened step period.
// Speed-level expectations follow whether SPEEDUP_EN is defined for the build.
`timescale 1ns/1ps
module tb_game_sequencer;

    logic       clock = 1'b0;
    logic       restart;
    logic       start;
    logic       stop;
    logic       hit;
    logic       step;
    logic       run_en;
    logic [2:0] life;
    logic [1:0] speed_level;
    logic [2:0] state;
    logic       game_over;
    logic       blink;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    game_sequencer #(
        .TICK_BASE      (32'd8),
        .SPEED_STEP     (32'd2),
        .LEVEL_UP_STEPS (16'd4),
        .LIVES          (3'd3),
        .INVUL_STEPS    (4'd2)
    ) dut (
        .clock       (clock),
        .restart     (restart),
        .start       (start),
        .stop        (stop),
        .hit         (hit),
        .step        (step),
        .run_en      (run_en),
        .life        (life),
        .speed_level (speed_level),
        .state       (state),
        .game_over   (game_over),
        .blink       (blink)
    );

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Returns edges until step is seen high, or -1 if the bound expires.
    task automatic wait_step(input int limit, output int n);
        n = 0;
        do begin
            cyc(1);
            n++;
        end while (step !== 1'b1 && n < limit);
        if (step !== 1'b1) n = -1;
    endtask

    task automatic do_reset();
        restart = 1'b0;
        start   = 1'b1;
        stop    = 1'b1;
        hit     = 1'b0;
        cyc(2);
        restart = 1'b1;
    endtask

    task automatic do_start();
        start = 1'b0;
        cyc(3);
        start = 1'b1;
    endtask

    task automatic pulse_hit();
        hit = 1'b1;
        cyc(1);
        hit = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
        checks++; if (life !== 3'd3) begin failures++; $display("FAIL reset_life got=%0d exp=3", life); end
        checks++; if (speed_level !== 2'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", speed_level); end
        checks++; if ({step, run_en, game_over, blink} !== 4'b0000) begin
            failures++; $display("FAIL reset_pulses got=%b exp=0000", {step, run_en, game_over, blink});
        end
    endtask

    task automatic test_start();
        int n;
        do_reset();
        start = 1'b0;
        cyc(2);
        checks++; if (state !== 3'd0) begin failures++; $display("FAIL start_early got=%0d exp=0", state); end
        cyc(1);
        start = 1'b1;
        checks++; if (state !== 3'd1) begin failures++; $display("FAIL start_state got=%0d exp=1", state); end
        checks++; if (run_en !== 1'b1 || life !== 3'd3) begin
            failures++; $display("FAIL start_outputs got=run_en %0d life %0d exp=run_en 1 life 3", run_en, life);
        end
        wait_step(40, n);
        checks++; if (n != 8) begin failures++; $display("FAIL first_step_latency got=%0d exp=8", n); end
        wait_step(40, n);
        checks++; if (n != 8) begin failures++; $display("FAIL step_period got=%0d exp=8", n); end
    endtask

    // Continues from test_start: runs right after a step, divider at 0.
    task automatic test_pause();
        int n;
        int cnt;
        cyc(3);
        stop = 1'b0;
        cyc(3);
        checks++; if (state !== 3'd2 || run_en !== 1'b0) begin
            failures++; $display("FAIL pause_enter got=state %0d run_en %0d exp=state 2 run_en 0", state, run_en);
        end
        stop = 1'b1;
        cnt  = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            if (step === 1'b1) cnt++;
        end
        checks++; if (cnt != 0) begin failures++; $display("FAIL pause_steps got=%0d exp=0", cnt); end
        checks++; if (state !== 3'd2) begin failures++; $display("FAIL pause_hold got=%0d exp=2", state); end
        do_start();
        checks++; if (state !== 3'd1) begin failures++; $display("FAIL resume_state got=%0d exp=1", state); end
        wait_step(40, n);
        checks++; if (n != 3) begin failures++; $display("FAIL resume_step got=%0d exp=3", n); end
        wait_step(40, n);
        checks++; if (n != 8) begin failures++; $display("FAIL resume_period got=%0d exp=8", n); end
    endtask

    task automatic test_hit();
        int n;
        do_reset();
        do_start();
        cyc(3);
        pulse_hit();
        checks++; if (state !== 3'd3 || life !== 3'd2 || run_en !== 1'b1) begin
            failures++; $display("FAIL hit_enter got=state %0d life %0d run_en %0d exp=state 3 life 2 run_en 1", state, life, run_en);
        end
        checks++; if (blink !== 1'b0) begin failures++; $display("FAIL hit_blink0 got=%0d exp=0", blink); end
        wait_step(40, n);
        checks++; if (n != 4) begin failures++; $display("FAIL hit_step1 got=%0d exp=4", n); end
        checks++; if (blink !== 1'b1) begin failures++; $display("FAIL hit_blink1 got=%0d exp=1", blink); end
        pulse_hit();
        checks++; if (state !== 3'd3 || life !== 3'd2) begin
            failures++; $display("FAIL hit_ignored got=state %0d life %0d exp=state 3 life 2", state, life);
        end
        wait_step(40, n);
        checks++; if (n != 7 || blink !== 1'b0 || state !== 3'd3) begin
            failures++; $display("FAIL hit_step2 got=n %0d blink %0d state %0d exp=n 7 blink 0 state 3", n, blink, state);
        end
        cyc(1);
        checks++; if (state !== 3'd1 || blink !== 1'b0) begin
            failures++; $display("FAIL hit_exit got=state %0d blink %0d exp=state 1 blink 0", state, blink);
        end
    endtask

    task automatic test_game_over();
        int n;
        int cnt;
        do_reset();
        do_start();
        for (int k = 0; k < 2; k++) begin
            cyc(2);
            pulse_hit();
            checks++; if (life !== 3'(2 - k) || state !== 3'd3) begin
                failures++; $display("FAIL over_hit%0d got=life %0d state %0d exp=life %0d state 3", k, life, state, 2 - k);
            end
            wait_step(40, n);
            wait_step(40, n);
            cyc(1);
            checks++; if (state !== 3'd1) begin failures++; $display("FAIL over_recover%0d got=%0d exp=1", k, state); end
        end
        cyc(1);
        pulse_hit();
        checks++; if (state !== 3'd4 || life !== 3'd0 || game_over !== 1'b1 || run_en !== 1'b0) begin
            failures++; $display("FAIL over_enter got=state %0d life %0d go %0d run_en %0d exp=4 0 1 0", state, life, game_over, run_en);
        end
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            if (step === 1'b1) cnt++;
        end
        checks++; if (cnt != 0) begin failures++; $display("FAIL over_steps got=%0d exp=0", cnt); end
        do_start();
        checks++; if (state !== 3'd1 || life !== 3'd3 || game_over !== 1'b0 || speed_level !== 2'd0) begin
            failures++; $display("FAIL over_restart got=state %0d life %0d go %0d lvl %0d exp=1 3 0 0", state, life, game_over, speed_level);
        end
        wait_step(40, n);
        checks++; if (n != 8) begin failures++; $display("FAIL over_first_step got=%0d exp=8", n); end
    endtask

    task automatic test_speed();
        int n;
        int exp_gap;
        int exp_lvl;
        do_reset();
        do_start();
        for (int i = 1; i <= 16; i++) begin
`ifdef SPEEDUP_EN
            exp_gap = (i <= 4) ? 8 : (i <= 8) ? 6 : (i <= 12) ? 4 : 2;
            exp_lvl = (i >= 12) ? 3 : i / 4;
`else
            exp_gap = 8;
            exp_lvl = 0;
`endif
            wait_step(40, n);
            checks++; if (n != exp_gap) begin failures++; $display("FAIL speed_gap%0d got=%0d exp=%0d", i, n, exp_gap); end
            checks++; if (speed_level !== 2'(exp_lvl)) begin
                failures++; $display("FAIL speed_level%0d got=%0d exp=%0d", i, speed_level, exp_lvl);
            end
        end
    endtask

    task automatic test_restart_mid_hit();
        do_reset();
        do_start();
        cyc(2);
        pulse_hit();
        cyc(2);
        checks++; if (state !== 3'd3) begin failures++; $display("FAIL rst_pre_hit got=%0d exp=3", state); end
        restart = 1'b0;
        cyc(1);
        restart = 1'b1;
        checks++; if (state !== 3'd0 || life !== 3'd3 || speed_level !== 2'd0) begin
            failures++; $display("FAIL rst_mid_hit got=state %0d life %0d lvl %0d exp=0 3 0", state, life, speed_level);
        end
        checks++; if ({step, run_en, game_over, blink} !== 4'b0000) begin
            failures++; $display("FAIL rst_mid_pulses got=%b exp=0000", {step, run_en, game_over, blink});
        end
    endtask

    task automatic test_start_stop_together();
        do_reset();
        do_start();
        cyc(2);
        start = 1'b0;
        stop  = 1'b0;
        cyc(3);
        checks++; if (state !== 3'd2) begin failures++; $display("FAIL both_in_run got=%0d exp=2", state); end
        start = 1'b1;
        stop  = 1'b1;
        cyc(3);
        start = 1'b0;
        stop  = 1'b0;
        cyc(4);
        checks++; if (state !== 3'd2) begin failures++; $display("FAIL both_in_pause got=%0d exp=2", state); end
        start = 1'b1;
        stop  = 1'b1;
    endtask

    initial begin
        restart = 1'b0;
        start   = 1'b1;
        stop    = 1'b1;
        hit     = 1'b0;
        test_reset();
        test_start();
        test_pause();
        test_hit();
        test_game_over();
        test_speed();
        test_restart_mid_hit();
        test_start_stop_together();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/game_sequencer.md
# game_sequencer

Top-level game controller for the little-dinosaur dot-matrix game. It turns the start and stop buttons and the collision flag into a game state machine (idle, run, pause, hit-recovery, over). It produces the single-cycle `step` pulse that advances the map, obstacle spawner and score. It also owns the life counter and the speed level. It sits between the button pins and the map, score and refresh datapaths, replacing their free-running `unit_clk` advance.

## Interface
Parameters:
- `TICK_BASE`, 32'd25000: clock cycles per step at speed level 0.
- `SPEED_STEP`, 32'd5000: cycles removed from the step period per speed level.
- `LEVEL_UP_STEPS`, 16'd64: steps in RUN/HIT between speed-level increments.
- `LIVES`, 3'd3: lives at game start; range 1..7.
- `INVUL_STEPS`, 4'd8: steps spent in HIT, during which `hit` is ignored.

Ports:
- `clock` in 1: system clock.
- `restart` in 1: synchronous, active-low reset.
- `start` in 1: start/resume button, active-low level.
- `stop` in 1: pause button, active-low level.
- `hit` in 1: collision flag from the hit detector, active-high level.
- `step` out 1: one-cycle advance pulse for the map, obstacle spawner and score.
- `run_en` out 1: high in RUN and HIT; gates the refresh animation.
- `life` out 3: remaining lives.
- `speed_level` out 2: current speed level, 0..3.
- `state` out 3: encoded game state.
- `game_over` out 1: high in OVER.
- `blink` out 1: toggles on every `step` in HIT; constant 0 in all other states.

## Operation
- Buttons:
  - Each button goes through a two-flop synchronizer and a falling-edge detector.
  - A press gives a one-cycle internal pulse on the 3rd rising `clock` edge after the pin falls.
  - Holding a button gives exactly one pulse.
- States and transitions:
  - IDLE → RUN on a start pulse. Entry clears the divider, the step counter and `speed_level`, and loads `life` = `LIVES`.
  - RUN → PAUSE on a stop pulse.
  - PAUSE → RUN on a start pulse. The divider count, step counter and level are held, not cleared.
  - RUN → HIT when `hit`=1 and `life` > 1. `life` decrements on the transition.
  - RUN → OVER when `hit`=1 and `life` = 1. `life` goes to 0.
  - HIT → RUN after `INVUL_STEPS` step pulses. `hit` and stop pulses are ignored in HIT.
  - OVER → RUN on a start pulse, with the same re-initialisation as IDLE → RUN.
- Simultaneous events:
  - RUN: `hit` wins over a stop pulse.
  - Start and stop pulses in the same cycle: stop wins in RUN; start is ignored elsewhere.
- Divider:
  - 32-bit counter, active only in RUN/HIT.
  - `step` fires when the counter equals period−1; the counter then returns to 0.
  - Period = `TICK_BASE` − `speed_level`×`SPEED_STEP`, computed in 32 bits. The period must stay ≥ 2 at level 3; parameter sets that violate this are illegal.
- Speed:
  - The step counter counts steps in RUN/HIT.
  - When it reaches `LEVEL_UP_STEPS`, it clears and `speed_level` increments, saturating at 3.
  - The new period applies from the next divider wrap.
- `restart` low at any clock edge, in any state, gives the full reset values on the next edge, mid-game included.

## Timing
- Reset values:
  - `state` = IDLE, `life` = `LIVES`, `speed_level` = 0.
  - `step`, `run_en`, `game_over` and `blink` = 0.
  - Divider, step counter and invulnerability counter = 0.
- Start latency: the first `step` arrives exactly `TICK_BASE` cycles after the cycle that enters RUN.
- Outputs are registered. `state`, `run_en` and `game_over` change on the edge that takes the transition.
- `hit` is sampled every cycle in RUN. The transition happens on the edge where `hit`=1 is seen, with no wait for `step`.
- `step` never asserts outside RUN/HIT, and never on two consecutive cycles.

## Configuration
- `SPEEDUP_EN` defined:
  - Speed levels advance as described above.
- `SPEEDUP_EN` undefined:
  - The step counter and level logic are not compiled.
  - `speed_level` is constant 0 and the period is always `TICK_BASE`.

## Structure
- Shared package `dino_pkg` holds:
  - State encoding: IDLE=3'd0, RUN=3'd1, PAUSE=3'd2, HIT=3'd3, OVER=3'd4.
  - `MAX_LEVEL` = 2'd3.
  - The parameter defaults listed under Interface.
- One sub-module, `btn_edge`: synchronizer plus falling-edge pulse, with ports `clock`, `restart`, `btn_n`, `press`. It is instantiated once for `start` and once for `stop`.

## Test plan
Bench parameters: `TICK_BASE`=8, `SPEED_STEP`=2, `LEVEL_UP_STEPS`=4, `LIVES`=3, `INVUL_STEPS`=2.
- Reset, then press start → `state` 0→1 three edges after the press; `life`=3; first `step` 8 cycles later, then every 8 cycles.
- Press stop after 5 divider cycles in RUN, wait 20 cycles, press start → no `step` while paused; next `step` 3 cycles after resume.
- In RUN, pulse `hit` for 1 cycle → `state`=HIT, `life`=2, `blink` toggling on each step; back to RUN after 2 steps; a second `hit` during HIT leaves `life`=2.
- Three separated hits → `life` 3→2→1→0; `state`=OVER; `game_over`=1; `step` stops; start → RUN with `life`=3.
- Run 16 steps with `SPEEDUP_EN` → `speed_level` 1, 2, 3 after steps 4, 8, 12; step spacing 8, 6, 4, 2; stays 3 after step 16. Without the macro: spacing stays 8 and `speed_level` stays 0.
- Drive `restart`=0 mid-HIT → next edge gives `state`=IDLE, `life`=3, all pulses 0. Start and stop pressed together in RUN → PAUSE.
